// File: rtl/ball_collision_responder.sv
// Per-ball speed registers with per-frame resolution of wall reflections, ball-ball speed swaps,
// periodic friction and potted-ball zeroing; pending events accumulate while a frame is processed.
//   state | meaning
//   IDLE  | accept shots, wait for startOfFrame
//   WALL  | one cycle per ball, reflect captured wall hits
//   BB    | swap speeds of the captured colliding pair
//   FRIC  | friction on every FRICTION_DIV-th frame, zero potted balls
//   DONE  | speeds_valid pulse
module ball_collision_responder #(
    parameter int N_BALLS       = 3,
    parameter int SPEED_W       = 11,
    parameter int FRICTION_DIV  = 4,
    parameter int FRICTION_STEP = 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              startOfFrame,
    input  logic [N_BALLS-1:0]                ballwall_collide,
    input  logic [1:0]                        collided_wall,
    input  logic [N_BALLS-1:0]                balls_collide,
    input  logic [1:0][3:0]                   Balls_col_ID,
    input  logic [N_BALLS-1:0]                balls_in_game,
    input  logic                              shot_valid,
    input  logic [3:0]                        shot_id,
    input  logic signed [SPEED_W-1:0]         shot_vx,
    input  logic signed [SPEED_W-1:0]         shot_vy,
    output logic                              shot_ready,
    output logic [N_BALLS-1:0][SPEED_W-1:0]   ball_vx,
    output logic [N_BALLS-1:0][SPEED_W-1:0]   ball_vy,
    output logic                              speeds_valid,
    output logic                              all_stopped
);

    localparam int FC_W = (FRICTION_DIV > 1) ? $clog2(FRICTION_DIV) : 1;
    localparam logic [3:0] N_ID = 4'(N_BALLS);
    localparam logic [3:0] LAST_ID = 4'(N_BALLS - 1);
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRICTION_DIV - 1);
    localparam logic signed [SPEED_W-1:0] S_MAX = {1'b0, {(SPEED_W-1){1'b1}}};
    localparam logic signed [SPEED_W-1:0] S_MIN = {1'b1, {(SPEED_W-1){1'b0}}};
    localparam logic signed [SPEED_W-1:0] STEP = SPEED_W'(FRICTION_STEP);

    typedef enum logic [2:0] {IDLE, WALL, BB, FRIC, DONE} state_t;

    state_t                     state;
    logic [3:0]                 idx;
    logic [FC_W-1:0]            frame_cnt;
    logic signed [SPEED_W-1:0]  vx [N_BALLS];
    logic signed [SPEED_W-1:0]  vy [N_BALLS];
    logic [N_BALLS-1:0]         pend_x, pend_y, work_x, work_y;
    logic                       pend_bb, work_bb;
    logic [3:0]                 pend_a, pend_b, work_a, work_b;
    logic [N_BALLS-1:0]         wall_x_now, wall_y_now;
    logic                       pair_ok, snapshot;
    logic signed [SPEED_W-1:0]  sel_ax, sel_ay, sel_bx, sel_by;

    function automatic logic signed [SPEED_W-1:0] neg_sat(input logic signed [SPEED_W-1:0] v);
        if (v == S_MIN)
            return S_MAX;
        return -v;
    endfunction

    function automatic logic signed [SPEED_W-1:0] fric(input logic signed [SPEED_W-1:0] v);
        if (v > STEP)
            return v - STEP;
        if (v < -STEP)
            return v + STEP;
        return '0;
    endfunction

    assign wall_x_now = ballwall_collide & {N_BALLS{collided_wall[0]}};
    assign wall_y_now = ballwall_collide & {N_BALLS{collided_wall[1]}};
    assign pair_ok = (|balls_collide) && (Balls_col_ID[0] != Balls_col_ID[1])
                     && (Balls_col_ID[0] < N_ID) && (Balls_col_ID[1] < N_ID);
    assign snapshot = (state == IDLE) && startOfFrame;

    always_comb begin
        sel_ax = '0;
        sel_ay = '0;
        sel_bx = '0;
        sel_by = '0;
        all_stopped = 1'b1;
        for (int i = 0; i < N_BALLS; i++) begin
            ball_vx[i] = vx[i];
            ball_vy[i] = vy[i];
            if (vx[i] != '0 || vy[i] != '0)
                all_stopped = 1'b0;
            if (work_a == 4'(i)) begin
                sel_ax = vx[i];
                sel_ay = vy[i];
            end
            if (work_b == 4'(i)) begin
                sel_bx = vx[i];
                sel_by = vy[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            idx          <= '0;
            frame_cnt    <= '0;
            pend_x       <= '0;
            pend_y       <= '0;
            work_x       <= '0;
            work_y       <= '0;
            pend_bb      <= 1'b0;
            work_bb      <= 1'b0;
            pend_a       <= '0;
            pend_b       <= '0;
            work_a       <= '0;
            work_b       <= '0;
            shot_ready   <= 1'b1;
            speeds_valid <= 1'b0;
            for (int i = 0; i < N_BALLS; i++) begin
                vx[i] <= '0;
                vy[i] <= '0;
            end
        end else begin
            // Events arriving with the snapshot belong to the next frame.
            if (snapshot) begin
                work_x  <= pend_x;
                work_y  <= pend_y;
                work_bb <= pend_bb;
                work_a  <= pend_a;
                work_b  <= pend_b;
                pend_x  <= wall_x_now;
                pend_y  <= wall_y_now;
                pend_bb <= pair_ok;
                if (pair_ok) begin
                    pend_a <= Balls_col_ID[0];
                    pend_b <= Balls_col_ID[1];
                end
            end else begin
                pend_x <= pend_x | wall_x_now;
                pend_y <= pend_y | wall_y_now;
                if (!pend_bb && pair_ok) begin
                    pend_bb <= 1'b1;
                    pend_a  <= Balls_col_ID[0];
                    pend_b  <= Balls_col_ID[1];
                end
            end

            speeds_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (shot_valid && shot_ready && shot_id < N_ID) begin
                        for (int i = 0; i < N_BALLS; i++) begin
                            if (shot_id == 4'(i)) begin
                                vx[i] <= shot_vx;
                                vy[i] <= shot_vy;
                            end
                        end
                    end
                    if (startOfFrame) begin
                        state      <= WALL;
                        idx        <= '0;
                        shot_ready <= 1'b0;
                    end
                end
                WALL: begin
                    for (int i = 0; i < N_BALLS; i++) begin
                        if (idx == 4'(i)) begin
                            if (work_x[i])
                                vx[i] <= neg_sat(vx[i]);
                            if (work_y[i])
                                vy[i] <= neg_sat(vy[i]);
                        end
                    end
                    if (idx == LAST_ID)
                        state <= BB;
                    else
                        idx <= idx + 4'd1;
                end
                BB: begin
                    if (work_bb) begin
                        for (int i = 0; i < N_BALLS; i++) begin
                            if (work_a == 4'(i)) begin
                                vx[i] <= sel_bx;
                                vy[i] <= sel_by;
                            end
                            if (work_b == 4'(i)) begin
                                vx[i] <= sel_ax;
                                vy[i] <= sel_ay;
                            end
                        end
                    end
                    state <= FRIC;
                end
                FRIC: begin
                    for (int i = 0; i < N_BALLS; i++) begin
                        if (!balls_in_game[i]) begin
                            vx[i] <= '0;
                            vy[i] <= '0;
                        end else if (frame_cnt == FC_LAST) begin
                            vx[i] <= fric(vx[i]);
                            vy[i] <= fric(vy[i]);
                        end
                    end
                    frame_cnt    <= (frame_cnt == FC_LAST) ? '0 : frame_cnt + 1'b1;
                    speeds_valid <= 1'b1;
                    state        <= DONE;
                end
                DONE: begin
                    shot_ready <= 1'b1;
                    state      <= IDLE;
                end
                default: begin
                    shot_ready <= 1'b1;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ball_collision_responder.sv
// Directed bench for ball_collision_responder: shots, wall reflection, pair swap, friction,
// saturation, potting, reset abort and next-frame deferral of coincident events.
module tb_ball_collision_responder;

    logic              clk = 1'b0;
    logic              reset;
    logic              startOfFrame;
    logic [2:0]        ballwall_collide;
    logic [1:0]        collided_wall;
    logic [2:0]        balls_collide;
    logic [1:0][3:0]   Balls_col_ID;
    logic [2:0]        balls_in_game;
    logic              shot_valid;
    logic [3:0]        shot_id;
    logic signed [10:0] shot_vx, shot_vy;
    logic              shot_ready;
    logic [2:0][10:0]  ball_vx, ball_vy;
    logic              speeds_valid;
    logic              all_stopped;

    int n_tests = 0;
    int n_fail  = 0;

    ball_collision_responder dut (
        .clk(clk), .reset(reset), .startOfFrame(startOfFrame),
        .ballwall_collide(ballwall_collide), .collided_wall(collided_wall),
        .balls_collide(balls_collide), .Balls_col_ID(Balls_col_ID),
        .balls_in_game(balls_in_game), .shot_valid(shot_valid), .shot_id(shot_id),
        .shot_vx(shot_vx), .shot_vy(shot_vy), .shot_ready(shot_ready),
        .ball_vx(ball_vx), .ball_vy(ball_vy), .speeds_valid(speeds_valid),
        .all_stopped(all_stopped)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_ball(input string tag, input int i, input int ex, input int ey);
        int gx, gy;
        gx = $signed(ball_vx[i]);
        gy = $signed(ball_vy[i]);
        check({tag, "_vx"}, gx, ex);
        check({tag, "_vy"}, gy, ey);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic shot(input int id, input int vx, input int vy);
        @(negedge clk);
        shot_valid = 1'b1;
        shot_id    = id[3:0];
        shot_vx    = vx[10:0];
        shot_vy    = vy[10:0];
        @(negedge clk);
        shot_valid = 1'b0;
    endtask

    task automatic wall_pulse(input logic [2:0] bwc, input logic [1:0] cw);
        @(negedge clk);
        ballwall_collide = bwc;
        collided_wall    = cw;
        @(negedge clk);
        ballwall_collide = '0;
        collided_wall    = '0;
    endtask

    task automatic pair_pulse(input int a, input int b);
        @(negedge clk);
        balls_collide   = '0;
        balls_collide[a] = 1'b1;
        balls_collide[b] = 1'b1;
        Balls_col_ID[0] = a[3:0];
        Balls_col_ID[1] = b[3:0];
        @(negedge clk);
        balls_collide = '0;
        Balls_col_ID  = '0;
    endtask

    // Frame with optional wall event in the same cycle as startOfFrame.
    task automatic frame_ev(input logic [2:0] bwc, input logic [1:0] cw);
        int n;
        bit got;
        @(negedge clk);
        startOfFrame     = 1'b1;
        ballwall_collide = bwc;
        collided_wall    = cw;
        n = 0;
        got = 1'b0;
        while (n < 20 && !got) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                startOfFrame     = 1'b0;
                ballwall_collide = '0;
                collided_wall    = '0;
            end
            if (speeds_valid)
                got = 1'b1;
        end
        check("latency", n, 6);
    endtask

    task automatic frame();
        frame_ev(3'b000, 2'b00);
    endtask

    initial begin
        reset = 1'b1;
        startOfFrame = 1'b0;
        ballwall_collide = '0;
        collided_wall = '0;
        balls_collide = '0;
        Balls_col_ID = '0;
        balls_in_game = 3'b111;
        shot_valid = 1'b0;
        shot_id = '0;
        shot_vx = '0;
        shot_vy = '0;

        // 1: reset state, shot, no-event frame
        do_reset();
        check("rst_ready", int'(shot_ready), 1);
        check("rst_valid", int'(speeds_valid), 0);
        check("rst_stopped", int'(all_stopped), 1);
        check_ball("rst_b0", 0, 0, 0);
        shot(0, 5, -3);
        check_ball("shot_b0", 0, 5, -3);
        check("moving", int'(all_stopped), 0);
        frame();
        check_ball("t1_b0", 0, 5, -3);
        check("t1_valid_pulse", int'(speeds_valid), 1);
        @(negedge clk);
        check("t1_valid_drop", int'(speeds_valid), 0);
        check("t1_ready", int'(shot_ready), 1);

        // 2: side wall then both walls
        wall_pulse(3'b001, 2'b01);
        frame();
        check_ball("t2_side", 0, -5, -3);
        wall_pulse(3'b001, 2'b11);
        frame();
        check_ball("t2_both", 0, 5, 3);

        // 3: first valid pair wins, second pair ignored
        do_reset();
        shot(0, 4, 0);
        shot(2, 7, -2);
        pair_pulse(0, 1);
        pair_pulse(1, 2);
        frame();
        check_ball("t3_b0", 0, 0, 0);
        check_ball("t3_b1", 1, 4, 0);
        check_ball("t3_b2", 2, 7, -2);

        // 4: friction every 4th frame
        do_reset();
        shot(1, 2, -1);
        frame();
        frame();
        frame();
        check_ball("t4_f3", 1, 2, -1);
        frame();
        check_ball("t4_f4", 1, 1, 0);
        frame();
        frame();
        frame();
        check_ball("t4_f7", 1, 1, 0);
        check("t4_f7_stopped", int'(all_stopped), 0);
        frame();
        check_ball("t4_f8", 1, 0, 0);
        check("t4_stopped", int'(all_stopped), 1);

        // 5: out-of-range shot, saturating negation, potted ball
        do_reset();
        shot(3, 9, 9);
        check("t5_badshot", int'(all_stopped), 1);
        shot(2, -1024, 7);
        wall_pulse(3'b100, 2'b01);
        frame();
        check_ball("t5_sat", 2, 1023, 7);
        balls_in_game = 3'b011;
        frame();
        check_ball("t5_potted", 2, 0, 0);
        balls_in_game = 3'b111;

        // 6: reset during WALL, then event coincident with startOfFrame deferred
        do_reset();
        shot(0, 5, -3);
        @(negedge clk);
        startOfFrame = 1'b1;
        @(negedge clk);
        startOfFrame = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t6_ready", int'(shot_ready), 1);
        check_ball("t6_abort", 0, 0, 0);
        shot(0, 5, -3);
        frame_ev(3'b001, 2'b01);
        check_ball("t6_same", 0, 5, -3);
        frame();
        check_ball("t6_next", 0, -5, -3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
